// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo and its read-side adapter.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Small circular prefetch buffer: push at tail, pop at head, explicit occupancy count.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 3,
  parameter int OCC_W      = clog2p1(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_W-1:0]      occ
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  // Explicit wrap keeps non-power-of-2 depths correct.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) tail <= wrap_inc(tail);
      if (pop)  head <= wrap_inc(head);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns the fifo's registered-read port into a valid/ready stream with a prefetch buffer.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BUF_DEPTH  = 3,
  localparam int OCC_W     = clog2p1(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [OCC_W-1:0]      occupancy
);

  localparam logic [OCC_W:0] DEPTH_L = (OCC_W + 1)'(BUF_DEPTH);

  logic             inflight;
  logic             pop;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   reserved;

  // A slot is reserved for every outstanding read, so the buffer can never overflow.
  assign reserved   = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
  assign fifo_rd_en = !rst && !fifo_empty && (reserved < DEPTH_L);

  always_ff @(posedge clk) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= fifo_rd_en;
  end

  assign m_valid   = (occ != '0);
  assign pop       = m_valid && m_ready;
  assign occupancy = occ;

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH),
    .OCC_W      (OCC_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_rdata),
    .pop       (pop),
    .head_data (m_data),
    .occ       (occ)
  );

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) reserved <= DEPTH_L);
  a_hold:        assert property (@(posedge clk) disable iff (rst)
                   m_valid && !m_ready |=> m_valid && $stable(m_data));
  a_no_rd_rst:   assert property (@(posedge clk) rst |-> !fifo_rd_en);

  // Tagged-index scoreboard: the beat landing with index sb_tag must leave with that index.
  logic [7:0]            sb_tag;
  logic [7:0]            sb_in_cnt;
  logic [7:0]            sb_out_cnt;
  logic [DATA_WIDTH-1:0] sb_data;
  logic                  sb_armed;

  always_ff @(posedge clk) sb_tag <= sb_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_in_cnt  <= '0;
      sb_out_cnt <= '0;
      sb_armed   <= 1'b0;
    end else begin
      if (inflight) begin
        sb_in_cnt <= sb_in_cnt + 1'b1;
        if (sb_in_cnt == sb_tag) begin
          sb_data  <= fifo_rdata;
          sb_armed <= 1'b1;
        end
      end
      if (pop) begin
        sb_out_cnt <= sb_out_cnt + 1'b1;
        if (sb_out_cnt == sb_tag) sb_armed <= 1'b0;
      end
    end
  end

  a_sb_data: assert property (@(posedge clk) disable iff (rst)
               pop && sb_armed && (sb_out_cnt == sb_tag) |-> m_data == sb_data);
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream with a queue-based fifo and stream reference model.
module tb_fifo_rd_stream;

  localparam int DW    = 8;
  localparam int DEPTH = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [1:0]    occupancy;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .occupancy  (occupancy)
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  bit  hide = 1'b0;
  bit  chk_en = 1'b0;
  int  exp_occ = 0;
  bit  inflight_m = 1'b0;
  int  cyc = 0;
  int  pops = 0;
  int  first_pop_cyc = -1;
  int  last_pop_cyc = -1;
  logic [DW-1:0] last_pop_data;

  logic          s_rd, s_valid;
  logic [DW-1:0] s_data;
  logic [1:0]    s_occ;

  // One clock of the environment: fifo model, stream scoreboard, occupancy model.
  task automatic tick();
    bit pop, accept, empty_s;
    logic [DW-1:0] e;
    fifo_empty = hide || (fifo_q.size() == 0);
    #1;
    s_rd = fifo_rd_en; s_valid = m_valid; s_data = m_data; s_occ = occupancy;
    empty_s = fifo_empty;
    pop = (s_valid === 1'b1) && m_ready;
    if (chk_en) begin
      checks++;
      if (s_occ !== 2'(exp_occ)) begin
        failures++; $display("FAIL occupancy cyc=%0d got=%0d exp=%0d", cyc, s_occ, exp_occ);
      end
      checks++;
      if (s_valid !== (exp_occ != 0)) begin
        failures++; $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, s_valid, exp_occ != 0);
      end
      checks++;
      if (int'(s_occ) + int'(inflight_m) > DEPTH) begin
        failures++; $display("FAIL reserve cyc=%0d occ=%0d inflight=%0d", cyc, s_occ, inflight_m);
      end
      if (rst) begin
        checks++;
        if (s_rd !== 1'b0) begin
          failures++; $display("FAIL rd_en_in_reset cyc=%0d got=%b exp=0", cyc, s_rd);
        end
      end
    end
    accept = (s_rd === 1'b1) && !empty_s && (fifo_q.size() > 0) && !rst;
    @(posedge clk);
    #1;
    if (rst) begin
      fifo_q.delete(); exp_q.delete();
      exp_occ = 0; inflight_m = 1'b0;
      fifo_rdata = DW'($urandom);
    end else begin
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL spurious_beat cyc=%0d got=%h exp=none", cyc, s_data);
        end else begin
          e = exp_q.pop_front();
          if (s_data !== e) begin
            failures++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", cyc, s_data, e);
          end
        end
        pops++;
        last_pop_data = s_data;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
      end
      exp_occ = exp_occ + int'(inflight_m) - int'(pop);
      if (accept) fifo_rdata = fifo_q.pop_front();
      else        fifo_rdata = DW'($urandom);
      inflight_m = accept;
    end
    cyc++;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ready = 1'b1; hide = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fifo_q.push_back(8'h11);
      tick();
      checks++;
      if (s_rd !== 1'b0) begin
        failures++; $display("FAIL reset_rd_en i=%0d got=%b exp=0", i, s_rd);
      end
      if (i > 0) begin
        checks++;
        if (s_valid !== 1'b0 || s_occ !== 2'd0) begin
          failures++; $display("FAIL reset_state i=%0d valid=%b occ=%0d exp 0/0", i, s_valid, s_occ);
        end
      end
    end
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    push_word(8'hA5);
    tick();
    checks++;
    if (s_rd !== 1'b1) begin failures++; $display("FAIL single_rd_en got=%b exp=1", s_rd); end
    tick();
    checks++;
    if (s_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", s_valid); end
    tick();
    checks++;
    if (s_valid !== 1'b1 || s_data !== 8'hA5) begin
      failures++; $display("FAIL single_beat valid=%b data=%h exp 1/a5", s_valid, s_data);
    end
    tick();
    checks++;
    if (s_valid !== 1'b0 || s_occ !== 2'd0) begin
      failures++; $display("FAIL single_after valid=%b occ=%0d exp 0/0", s_valid, s_occ);
    end
  endtask

  task automatic test_back_to_back();
    int start, p0;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(8'(i));
    first_pop_cyc = -1; start = cyc; p0 = pops;
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) tick();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL stream_timeout left=%0d exp=0", exp_q.size()); end
    checks++;
    if (pops - p0 != 16) begin failures++; $display("FAIL stream_count got=%0d exp=16", pops - p0); end
    checks++;
    if (first_pop_cyc - start != 2) begin
      failures++; $display("FAIL stream_latency got=%0d exp=2", first_pop_cyc - start);
    end
    checks++;
    if (last_pop_cyc - first_pop_cyc != 15) begin
      failures++; $display("FAIL stream_bubbles span=%0d exp=15", last_pop_cyc - first_pop_cyc);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d0;
    int p0;
    m_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 8; i++) push_word(DW'($urandom));
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) d0 = s_data;
      if (i > 2) begin
        checks++;
        if (s_valid !== 1'b1 || s_data !== d0) begin
          failures++; $display("FAIL bp_stable i=%0d valid=%b data=%h exp 1/%h", i, s_valid, s_data, d0);
        end
      end
    end
    checks++;
    if (s_occ !== 2'd3 || s_rd !== 1'b0) begin
      failures++; $display("FAIL bp_saturate occ=%0d rd_en=%b exp 3/0", s_occ, s_rd);
    end
    checks++;
    if (fifo_q.size() != 5) begin failures++; $display("FAIL bp_reads left=%0d exp=5", fifo_q.size()); end
    m_ready = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) tick();
    checks++;
    if (exp_q.size() != 0 || pops - p0 != 8) begin
      failures++; $display("FAIL bp_drain popped=%0d left=%0d exp 8/0", pops - p0, exp_q.size());
    end
  endtask

  task automatic test_empty_toggle();
    int p0;
    p0 = pops;
    for (int i = 0; i < 24; i++) push_word(DW'($urandom));
    for (int n = 0; n < 300 && exp_q.size() > 0; n++) begin
      hide = ~hide;
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    hide = 1'b0;
    checks++;
    if (exp_q.size() != 0 || pops - p0 != 24) begin
      failures++; $display("FAIL toggle_drain popped=%0d left=%0d exp 24/0", pops - p0, exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int p0, p1;
    m_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 16; i++) push_word(8'h40 + 8'(i));
    for (int n = 0; n < 30 && pops - p0 < 5; n++) tick();
    checks++;
    if (pops - p0 != 5) begin failures++; $display("FAIL midrst_reach got=%0d exp=5", pops - p0); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (s_valid !== 1'b0 || s_occ !== 2'd0) begin
      failures++; $display("FAIL midrst_clear valid=%b occ=%0d exp 0/0", s_valid, s_occ);
    end
    p1 = pops;
    push_word(8'h3C);
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) tick();
    checks++;
    if (pops - p1 != 1 || last_pop_data !== 8'h3C) begin
      failures++; $display("FAIL midrst_fresh count=%0d data=%h exp 1/3c", pops - p1, last_pop_data);
    end
    for (int n = 0; n < 4; n++) tick();
  endtask

  initial begin
    rst = 1'b1; m_ready = 1'b0; fifo_empty = 1'b1; fifo_rdata = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_empty_toggle();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
